// File: rtl/cnt_ones_pipe_pkg.sv
// Shared types and helpers for the pipelined population-count block.
package cnt_ones_pipe_pkg;

  localparam int DEF_WI_SZ       = 32;
  localparam int DEF_LVL_PER_STG = 2;
  localparam int DEF_ACC_SZ      = 16;

  // Per-stage sideband: word valid and end-of-packet marker.
  typedef struct packed {
    logic vld;
    logic last;
  } sb_t;

  // Ceiling division, used to turn tree levels into register stages.
  function automatic int clog2_ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Bit offset of tree level k inside the flattened node vector.
  // Level j holds (pw >> j) partial sums of j+1 bits each.
  function automatic int lvl_off(input int pw, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) off += (pw >> j) * (j + 1);
    return off;
  endfunction

endpackage

// File: rtl/cnt_ones_lvl.sv
// One combinational adder-tree level: pairs up N_IN partial sums of W_IN bits
// and produces N_IN/2 sums of W_IN+1 bits, so no carry is ever lost.
module cnt_ones_lvl
  import cnt_ones_pipe_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W_IN = 1
) (
  input  logic [N_IN*W_IN-1:0]       part_i,
  output logic [(N_IN/2)*(W_IN+1)-1:0] sum_o
);

  localparam int WO = W_IN + 1;

  // Add adjacent pairs, each result one bit wider than its operands.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N_IN / 2; i++) begin
      sum_o[i*WO +: WO] = WO'(part_i[(2*i)*W_IN +: W_IN])
                        + WO'(part_i[(2*i+1)*W_IN +: W_IN]);
    end
  end

endmodule

// File: rtl/cnt_ones_pipe.sv
// Pipelined population count with valid/ready handshake.
// The input word is zero-padded to a power of two and reduced by a binary
// adder tree; a register stage follows every LVL_PER_STG levels and the final
// level. Whole pipe advances together (no bubble collapsing).
// Optional per-packet saturating accumulator: define CNT_ONES_PIPE_ACC_EN.
module cnt_ones_pipe
  import cnt_ones_pipe_pkg::*;
#(
  parameter int WI_SZ       = DEF_WI_SZ,
  parameter int LVL_PER_STG = DEF_LVL_PER_STG,
  parameter int ACC_SZ      = DEF_ACC_SZ
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WI_SZ-1:0]           in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WI_SZ+1)-1:0] out_cnt,
  output logic                       out_last,
  output logic [ACC_SZ-1:0]          out_acc
);

  localparam int LEVELS  = $clog2(WI_SZ);
  localparam int PW      = 1 << LEVELS;
  localparam int NSTG    = clog2_ceil_div(LEVELS, LVL_PER_STG);
  localparam int WO_SZ   = $clog2(WI_SZ + 1);
  localparam int TOT     = lvl_off(PW, LEVELS + 1);
  localparam int OFF_FIN = lvl_off(PW, LEVELS);

  logic            adv;
  logic [TOT-1:0]  node;
  sb_t             sb_q [NSTG];

  // A stalled output freezes every stage so nothing is overwritten.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Level 0 is the padded word itself: padding bits count as zero.
  assign node[PW-1:0] = PW'(in_data);

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NI    = PW >> (k - 1);
    localparam int WOUT  = (NI / 2) * (k + 1);
    localparam int OFF_I = lvl_off(PW, k - 1);
    localparam int OFF_O = lvl_off(PW, k);

    logic [WOUT-1:0] sum_c;

    cnt_ones_lvl #(
      .N_IN (NI),
      .W_IN (k)
    ) u_lvl (
      .part_i (node[OFF_I +: NI*k]),
      .sum_o  (sum_c)
    );

    if ((k % LVL_PER_STG == 0) || (k == LEVELS)) begin : g_reg
      logic [WOUT-1:0] sum_q;

      // Stage boundary register; cleared on reset so out_cnt starts at 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   sum_q <= '0;
        else if (adv) sum_q <= sum_c;
      end

      assign node[OFF_O +: WOUT] = sum_q;
    end else begin : g_comb
      assign node[OFF_O +: WOUT] = sum_c;
    end
  end

  // Valid/last sideband shifts in lock-step with the tree registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSTG; s++) sb_q[s] <= '0;
    end else if (adv) begin
      sb_q[0].vld  <= in_valid;
      sb_q[0].last <= in_last;
      for (int s = 1; s < NSTG; s++) sb_q[s] <= sb_q[s-1];
    end
  end

  assign out_valid = sb_q[NSTG-1].vld;
  assign out_last  = sb_q[NSTG-1].last;
  assign out_cnt   = WO_SZ'(node[OFF_FIN +: LEVELS+1]);

`ifdef CNT_ONES_PIPE_ACC_EN
  logic [ACC_SZ-1:0] acc_q;
  logic [ACC_SZ-1:0] acc_d;

  // Add with clamp at the all-ones value instead of wrapping.
  function automatic logic [ACC_SZ-1:0] sat_add(input logic [ACC_SZ-1:0] a,
                                                input logic [WO_SZ-1:0]  b);
    logic [ACC_SZ:0] s;
    s = {1'b0, a} + (ACC_SZ+1)'(b);
    return s[ACC_SZ] ? {ACC_SZ{1'b1}} : s[ACC_SZ-1:0];
  endfunction

  assign out_acc = sat_add(acc_q, out_cnt);
  assign acc_d   = out_last ? '0 : out_acc;

  // Running packet total; restarts after the last beat is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       acc_q <= '0;
    else if (out_valid && out_ready)  acc_q <= acc_d;
  end
`else
  assign out_acc = '0;
`endif

endmodule

// File: tb/tb_cnt_ones_pipe.sv
// Self-checking bench for cnt_ones_pipe: directed latency/backpressure/reset
// cases plus a randomized handshake stream against a queue-based model.
module tb_cnt_ones_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // DUT A: 32-bit default geometry, narrow accumulator so saturation is reachable
  logic        a_in_valid = 0, a_in_ready, a_in_last = 0, a_out_valid, a_out_ready = 1, a_out_last;
  logic [31:0] a_in_data = '0;
  logic [5:0]  a_out_cnt;
  logic [7:0]  a_out_acc;

  cnt_ones_pipe #(.WI_SZ(32), .LVL_PER_STG(2), .ACC_SZ(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_cnt(a_out_cnt), .out_last(a_out_last), .out_acc(a_out_acc));

  // DUT B: WI_SZ=5 (padded to 8), one level per stage -> 3 stages
  logic       b_in_valid = 0, b_in_ready, b_out_valid, b_out_last;
  logic [4:0] b_in_data = '0;
  logic [2:0] b_out_cnt;
  logic [3:0] b_out_acc;

  cnt_ones_pipe #(.WI_SZ(5), .LVL_PER_STG(1), .ACC_SZ(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(1'b0), .out_valid(b_out_valid),
    .out_ready(1'b1), .out_cnt(b_out_cnt), .out_last(b_out_last), .out_acc(b_out_acc));

  // DUT C: WI_SZ=3, single stage, used for the packet accumulation case
  logic       c_in_valid = 0, c_in_ready, c_in_last = 0, c_out_valid, c_out_last;
  logic [2:0] c_in_data = '0;
  logic [1:0] c_out_cnt;
  logic [3:0] c_out_acc;

  cnt_ones_pipe #(.WI_SZ(3), .LVL_PER_STG(2), .ACC_SZ(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(1'b1), .out_cnt(c_out_cnt), .out_last(c_out_last), .out_acc(c_out_acc));

  // Reference model for DUT A: FIFO of accepted words, packet running sum
  typedef struct packed { logic [5:0] cnt; logic last; } exp_t;
  exp_t q[$];
  int   acc_m = 0;
  logic stall_p = 0;
  logic [5:0] hold_cnt;
  logic hold_last;
  logic [7:0] hold_acc;

  always @(negedge clk) begin
    exp_t e;
    int   ea;
    if (!rst_n) begin
      q.delete();
      acc_m   = 0;
      stall_p = 0;
    end else begin
      chk("in_ready_rule", 32'(a_in_ready), 32'(!a_out_valid || a_out_ready));
      if (stall_p) begin
        chk("hold_vld",  32'(a_out_valid), 32'd1);
        chk("hold_cnt",  32'(a_out_cnt),   32'(hold_cnt));
        chk("hold_last", 32'(a_out_last),  32'(hold_last));
        chk("hold_acc",  32'(a_out_acc),   32'(hold_acc));
      end
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'(a_out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_cnt",  32'(a_out_cnt),  32'(e.cnt));
          chk("sb_last", 32'(a_out_last), 32'(e.last));
`ifdef CNT_ONES_PIPE_ACC_EN
          ea = acc_m + int'(e.cnt);
          if (ea > 255) ea = 255;
          chk("sb_acc", 32'(a_out_acc), 32'(ea));
          acc_m = e.last ? 0 : ea;
`else
          ea = 0;
          chk("sb_acc_off", 32'(a_out_acc), 32'(ea));
`endif
        end
      end
      stall_p   = a_out_valid && !a_out_ready;
      hold_cnt  = a_out_cnt;
      hold_last = a_out_last;
      hold_acc  = a_out_acc;
      if (a_in_valid && a_in_ready)
        q.push_back('{cnt: 6'($countones(a_in_data)), last: a_in_last});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "timeout");
  end

  logic [31:0] b2b_d [4] = '{32'h0, 32'h1, 32'h8000_0001, 32'hAAAA_AAAA};
  int          b2b_e [4] = '{0, 1, 2, 16};
  logic [4:0]  bw_d  [4] = '{5'b10111, 5'b11111, 5'b00000, 5'b01000};
  int          bw_e  [4] = '{4, 5, 0, 1};
  logic [2:0]  c_d   [6] = '{3'd7, 3'd1, 3'd3, 3'd5, 3'd7, 3'd7};
  logic        c_l   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int          c_cnt [6] = '{3, 1, 2, 2, 3, 3};
  int          c_acc [6] = '{3, 4, 6, 2, 3, 6};

  initial begin
    int got_cnt[$];
    int got_it[$];

    // Reset state
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_cnt",   32'(a_out_cnt),   32'd0);
    chk("rst_out_last",  32'(a_out_last),  32'd0);
    chk("rst_out_acc",   32'(a_out_acc),   32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_b_valid",   32'(b_out_valid), 32'd0);
    chk("rst_c_valid",   32'(c_out_valid), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Latency: all-ones word, out_valid exactly 3 cycles after acceptance
    @(posedge clk);
    for (int it = 0; it < 6; it++) begin
      #1;
      a_in_valid = (it == 0);
      a_in_data  = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("lat_valid", 32'(a_out_valid), 32'(it == 3));
      if (it == 3) chk("lat_cnt_all_ones", 32'(a_out_cnt), 32'd32);
      @(posedge clk);
    end

    // Back-to-back words come out on consecutive cycles
    for (int it = 0; it < 10; it++) begin
      #1;
      a_in_valid = (it < 4);
      a_in_data  = b2b_d[it % 4];
      @(negedge clk);
      if (a_out_valid) begin
        got_cnt.push_back(int'(a_out_cnt));
        got_it.push_back(it);
      end
      @(posedge clk);
    end
    chk("b2b_count", 32'(got_cnt.size()), 32'd4);
    for (int j = 0; j < 4 && j < got_cnt.size(); j++) begin
      chk("b2b_cnt", 32'(got_cnt[j]), 32'(b2b_e[j]));
      chk("b2b_cycle", 32'(got_it[j]), 32'(got_it[0] + j));
    end

    // Backpressure: fill the pipe with out_ready low, then release
    #1;
    a_out_ready = 1'b0;
    for (int it = 0; it < 8; it++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'((64'd1 << (it + 1)) - 64'd1);
      @(negedge clk);
      if (it >= 3) begin
        chk("stall_in_ready", 32'(a_in_ready),  32'd0);
        chk("stall_valid",    32'(a_out_valid), 32'd1);
        chk("stall_cnt",      32'(a_out_cnt),   32'd1);
      end
      @(posedge clk); #1;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
    chk("stall_drain_empty", 32'(q.size()), 32'd0);

    // Padded width: WI_SZ=5, three stages
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1;
      b_in_data  = bw_d[v];
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        @(negedge clk);
        chk("w5_valid", 32'(b_out_valid), 32'(i == 3));
        if (i == 3) chk("w5_cnt", 32'(b_out_cnt), 32'(bw_e[v]));
      end
    end

    // Packet accumulation at WI_SZ=3, single stage
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      c_in_valid = 1'b1;
      c_in_data  = c_d[k];
      c_in_last  = c_l[k];
      @(posedge clk);
      @(negedge clk);
      chk("w3_valid", 32'(c_out_valid), 32'd1);
      chk("w3_cnt",   32'(c_out_cnt),   32'(c_cnt[k]));
      chk("w3_last",  32'(c_out_last),  32'(c_l[k]));
`ifdef CNT_ONES_PIPE_ACC_EN
      chk("w3_acc",   32'(c_out_acc),   32'(c_acc[k]));
`else
      chk("w3_acc_off", 32'(c_out_acc), 32'd0);
`endif
    end
    c_in_valid = 1'b0;
    c_in_last  = 1'b0;

    // Randomized handshake stream on DUT A
    for (int i = 0; i < 600; i++) begin
      int r;
      @(posedge clk); #1;
      r = int'($urandom_range(0, 9));
      a_in_valid  = ($urandom_range(0, 9) < 7);
      a_in_data   = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
      a_in_last   = ($urandom_range(0, 15) == 0);
      a_out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    a_in_valid  = 1'b0;
    a_in_last   = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
    chk("rand_drain_empty", 32'(q.size()), 32'd0);

    // Reset mid-stream: one word at the output, two more in flight
    for (int it = 0; it < 3; it++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1;
      a_in_data  = 32'hFFFF_FFFF;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
    chk("pre_rst_cnt",   32'(a_out_cnt),   32'd32);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_cnt",   32'(a_out_cnt),   32'd0);
    chk("mid_rst_acc",   32'(a_out_acc),   32'd0);
    chk("mid_rst_ready", 32'(a_in_ready),  32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_out", 32'(a_out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
